// File: rtl/cache_arbiter.sv
// Two-master arbiter sharing one physical-memory port between the I-cache and D-cache.
// Round-robin on ties; the owner keeps the port until the downstream completion pulse.
module cache_arbiter #(
    parameter int s_line = 256,
    parameter int s_addr = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic              i_pmem_write,
    input  logic [s_addr-1:0] i_pmem_address,
    input  logic [s_line-1:0] i_pmem_wdata,
    output logic [s_line-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [s_addr-1:0] d_pmem_address,
    input  logic [s_line-1:0] d_pmem_wdata,
    output logic [s_line-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [s_addr-1:0] pmem_address,
    output logic [s_line-1:0] pmem_wdata,
    input  logic [s_line-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [1:0]        grant
);

    // Encoding doubles as the one-hot {d, i} grant vector.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SERVE_I = 2'b01,
        SERVE_D = 2'b10
    } state_t;

    state_t state_r;
    logic   last_r;     // 1'b1: D was granted most recently
    logic   i_req_s;
    logic   d_req_s;

    assign i_req_s = i_pmem_read | i_pmem_write;
    assign d_req_s = d_pmem_read | d_pmem_write;

    // Arbitration FSM and round-robin history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            last_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_req_s && d_req_s) begin
                        if (last_r) begin
                            state_r <= SERVE_I;
                            last_r  <= 1'b0;
                        end else begin
                            state_r <= SERVE_D;
                            last_r  <= 1'b1;
                        end
                    end else if (i_req_s) begin
                        state_r <= SERVE_I;
                        last_r  <= 1'b0;
                    end else if (d_req_s) begin
                        state_r <= SERVE_D;
                        last_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SERVE_I: begin
                    if (pmem_resp) begin
                        state_r <= IDLE;
                    end
                end
                SERVE_D: begin
                    if (pmem_resp) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign grant = state_r;

    // Downstream command mux and completion routing; the owner's live inputs pass straight through.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = {s_addr{1'b0}};
        pmem_wdata   = {s_line{1'b0}};
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        case (state_r)
            SERVE_I: begin
                pmem_read    = i_pmem_read;
                pmem_write   = i_pmem_write;
                pmem_address = i_pmem_address;
                pmem_wdata   = i_pmem_wdata;
                i_pmem_resp  = pmem_resp;
            end
            SERVE_D: begin
                pmem_read    = d_pmem_read;
                pmem_write   = d_pmem_write;
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                d_pmem_resp  = pmem_resp;
            end
            default: begin
                pmem_read    = 1'b0;
                pmem_write   = 1'b0;
            end
        endcase
    end

    // Read data is qualified only by resp, so it fans out to both caches.
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule
